alu_operand_loader: RTL and testbench

- Upstream input stage for the 4-bit ALU on the board.
- Collects operand A, operand B and the 4-bit operation code from the slide switches, one step per press of a "next" push-button.
- Presents all three as stable registered values with a valid flag.
- Contains its own button synchronizer/debouncer and a 4-state entry FSM.

---
 rtl/alu_operand_loader.sv | 124 ++++++++++++
 tb/tb_alu_operand_loader.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_loader.sv
// Operand entry stage for the board ALU: captures A, B and the opcode from the switches,
// stepping once per debounced press of the "next" button, with a level-sensitive clear.
module alu_operand_loader #(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int MODE_MAX        = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] sw,
  input  logic [3:0]   sw_mode,
  input  logic         btn_next,
  input  logic         btn_clear,
  output logic [N-1:0] in1,
  output logic [N-1:0] in2,
  output logic [3:0]   mode,
  output logic         valid,
  output logic         mode_err,
  output logic [1:0]   stage
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]    MODE_MAX_L = 4'(MODE_MAX);

  typedef enum logic [1:0] {
    LOAD_A    = 2'd0,
    LOAD_B    = 2'd1,
    LOAD_MODE = 2'd2,
    READY     = 2'd3
  } state_t;

  state_t        state_q;
  logic [1:0]    next_sync_q;
  logic [1:0]    clear_sync_q;
  logic          db_q;
  logic          db_dly_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          db_d;
  logic          next_synced;
  logic          clear;
  logic          press;

  assign next_synced = next_sync_q[1];
  assign clear       = clear_sync_q[1];
  assign press       = db_q & ~db_dly_q;
  assign stage       = state_q;

  // The debounced level only follows the synced input after it has disagreed for
  // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (next_synced != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d = next_synced;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      next_sync_q  <= '0;
      clear_sync_q <= '0;
      db_q         <= 1'b0;
      db_dly_q     <= 1'b0;
      cnt_q        <= '0;
    end else begin
      next_sync_q  <= {next_sync_q[0], btn_next};
      clear_sync_q <= {clear_sync_q[0], btn_clear};
      db_q         <= db_d;
      db_dly_q     <= db_q;
      cnt_q        <= cnt_d;
    end
  end

  // Clear wins over a press arriving on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= LOAD_A;
      in1      <= '0;
      in2      <= '0;
      mode     <= '0;
      valid    <= 1'b0;
      mode_err <= 1'b0;
    end else if (clear) begin
      state_q  <= LOAD_A;
      in1      <= '0;
      in2      <= '0;
      mode     <= '0;
      valid    <= 1'b0;
      mode_err <= 1'b0;
    end else if (press) begin
      case (state_q)
        LOAD_A: begin
          in1     <= sw;
          state_q <= LOAD_B;
        end
        LOAD_B: begin
          in2     <= sw;
          state_q <= LOAD_MODE;
        end
        LOAD_MODE: begin
          mode     <= sw_mode;
          mode_err <= (sw_mode > MODE_MAX_L);
          valid    <= 1'b1;
          state_q  <= READY;
        end
        READY: begin
          valid   <= 1'b0;
          state_q <= LOAD_A;
        end
        default: begin
          valid   <= 1'b0;
          state_q <= LOAD_A;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_operand_loader.sv
// Self-checking bench for alu_operand_loader: directed scenarios plus random button/switch
// traffic, all compared against a window-based behavioural model.
module tb_alu_operand_loader;
  localparam int N        = 4;
  localparam int DB       = 4;
  localparam int MODE_MAX = 9;

  logic         clk       = 1'b0;
  logic         rst       = 1'b1;
  logic [N-1:0] sw        = '0;
  logic [3:0]   sw_mode   = '0;
  logic         btn_next  = 1'b0;
  logic         btn_clear = 1'b0;
  logic [N-1:0] in1;
  logic [N-1:0] in2;
  logic [3:0]   mode;
  logic         valid;
  logic         mode_err;
  logic [1:0]   stage;

  int n_checks = 0;
  int n_errors = 0;

  alu_operand_loader #(
    .N(N),
    .DEBOUNCE_CYCLES(DB),
    .MODE_MAX(MODE_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sw(sw),
    .sw_mode(sw_mode),
    .btn_next(btn_next),
    .btn_clear(btn_clear),
    .in1(in1),
    .in2(in2),
    .mode(mode),
    .valid(valid),
    .mode_err(mode_err),
    .stage(stage)
  );

  always #5 clk = ~clk;

  // Reference model: the debounced level flips once the last DB synced samples all
  // disagree with it; a press is a rising edge of that level.
  logic          m_n1, m_n2, m_c1, m_c2, m_db, m_dbq;
  logic [DB-2:0] m_hist;
  logic [DB-1:0] m_win;
  logic          m_press;
  int            m_state;
  logic [N-1:0]  m_in1, m_in2;
  logic [3:0]    m_mode;
  logic          m_err;

  assign m_win   = {m_hist, m_n2};
  assign m_press = m_db & ~m_dbq;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_n1 <= 1'b0; m_n2 <= 1'b0; m_c1 <= 1'b0; m_c2 <= 1'b0;
      m_db <= 1'b0; m_dbq <= 1'b0; m_hist <= '0;
      m_state <= 0; m_in1 <= '0; m_in2 <= '0; m_mode <= '0; m_err <= 1'b0;
    end else begin
      m_n1   <= btn_next;
      m_n2   <= m_n1;
      m_c1   <= btn_clear;
      m_c2   <= m_c1;
      m_hist <= m_win[DB-2:0];
      m_dbq  <= m_db;
      if (m_win == {DB{~m_db}}) m_db <= ~m_db;
      if (m_c2) begin
        m_state <= 0; m_in1 <= '0; m_in2 <= '0; m_mode <= '0; m_err <= 1'b0;
      end else if (m_press) begin
        case (m_state)
          0: begin m_in1 <= sw; m_state <= 1; end
          1: begin m_in2 <= sw; m_state <= 2; end
          2: begin
            m_mode  <= sw_mode;
            m_err   <= (int'(sw_mode) > MODE_MAX);
            m_state <= 3;
          end
          default: m_state <= 0;
        endcase
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check_val("in1", 32'(in1), 32'(m_in1));
    check_val("in2", 32'(in2), 32'(m_in2));
    check_val("mode", 32'(mode), 32'(m_mode));
    check_val("mode_err", 32'(mode_err), 32'(m_err));
    check_val("stage", 32'(stage), 32'(m_state));
    check_val("valid", 32'(valid), 32'(m_state == 3));
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      check_all();
    end
  endtask

  task automatic press(input int hold);
    btn_next = 1'b1;
    tick(hold);
    btn_next = 1'b0;
    tick(DB + 4);
  endtask

  initial begin
    int k;
    logic [N-1:0] saved;

    // T1: reset and idle
    #2 rst = 1'b0;
    #1;
    check_val("t1_rst_in1", 32'(in1), 0);
    check_val("t1_rst_stage", 32'(stage), 0);
    check_val("t1_rst_valid", 32'(valid), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick(50);
    check_val("t1_stage", 32'(stage), 0);
    $display("T1 reset idle: stage=%0d valid=%0d", stage, valid);

    // T2: full entry and valid latency
    sw = 4'h5;
    press(10);
    check_val("t2_stage_b", 32'(stage), 1);
    sw = 4'h3;
    press(10);
    check_val("t2_stage_m", 32'(stage), 2);
    sw_mode  = 4'h2;
    btn_next = 1'b1;
    k = 0;
    while (valid !== 1'b1 && k < 20) begin
      tick(1);
      k++;
    end
    check_val("t2_valid_edges", 32'(k - 1), 6);
    tick(3);
    btn_next = 1'b0;
    tick(DB + 4);
    check_val("t2_in1", 32'(in1), 5);
    check_val("t2_in2", 32'(in2), 3);
    check_val("t2_mode", 32'(mode), 2);
    check_val("t2_stage_r", 32'(stage), 3);
    $display("T2 entry: in1=%0h in2=%0h mode=%0h valid=%0d", in1, in2, mode, valid);

    // T3: bounce rejection, then one clean press
    press(10);
    check_val("t3_stage0", 32'(stage), 0);
    repeat (5) begin
      btn_next = 1'b1;
      tick(2);
      btn_next = 1'b0;
      tick(2);
    end
    tick(DB + 4);
    check_val("t3_bounce_stage", 32'(stage), 0);
    saved = N'($urandom_range(1, 15));
    sw = saved;
    press(10);
    check_val("t3_one_stage", 32'(stage), 1);
    check_val("t3_one_in1", 32'(in1), 32'(saved));
    $display("T3 bounce: stage=%0d in1=%0h", stage, in1);

    // T4: illegal then legal opcode
    btn_clear = 1'b1;
    tick(4);
    btn_clear = 1'b0;
    tick(4);
    check_val("t4_clr_stage", 32'(stage), 0);
    sw = 4'h1; sw_mode = 4'hC;
    press(6); press(6); press(6);
    check_val("t4_mode", 32'(mode), 12);
    check_val("t4_err", 32'(mode_err), 1);
    check_val("t4_valid", 32'(valid), 1);
    press(6);
    sw_mode = 4'h9;
    press(6); press(6); press(6);
    check_val("t4_mode9", 32'(mode), 9);
    check_val("t4_err9", 32'(mode_err), 0);
    $display("T4 opcode: mode=%0h mode_err=%0d", mode, mode_err);

    // T5: clear beats press in LOAD_MODE
    press(6);
    sw = 4'h6; press(6);
    sw = 4'h7; press(6);
    check_val("t5_stage2", 32'(stage), 2);
    sw_mode   = 4'h5;
    btn_clear = 1'b1;
    btn_next  = 1'b1;
    tick(10);
    btn_clear = 1'b0;
    btn_next  = 1'b0;
    tick(DB + 4);
    check_val("t5_in1", 32'(in1), 0);
    check_val("t5_in2", 32'(in2), 0);
    check_val("t5_mode", 32'(mode), 0);
    check_val("t5_stage", 32'(stage), 0);
    $display("T5 clear: stage=%0d mode=%0h", stage, mode);

    // T6: asynchronous reset mid-debounce with button still held
    sw = 4'h7;
    press(6);
    check_val("t6_pre_in1", 32'(in1), 7);
    sw       = 4'hA;
    btn_next = 1'b1;
    tick(2);
    rst = 1'b0;
    #1;
    check_val("t6_rst_in1", 32'(in1), 0);
    check_val("t6_rst_stage", 32'(stage), 0);
    @(negedge clk);
    rst = 1'b1;
    k = 0;
    while (stage !== 2'd1 && k < 20) begin
      tick(1);
      k++;
    end
    check_val("t6_edges", 32'(k), DB + 3);
    check_val("t6_in1", 32'(in1), 4'hA);
    btn_next = 1'b0;
    tick(DB + 4);
    $display("T6 reset mid-debounce: stage=%0d in1=%0h", stage, in1);

    // Random traffic
    repeat (60) begin
      btn_next  = 1'($urandom_range(0, 1));
      btn_clear = ($urandom_range(0, 14) == 0);
      repeat ($urandom_range(1, 8)) begin
        sw      = N'($urandom);
        sw_mode = 4'($urandom);
        tick(1);
      end
    end
    btn_next  = 1'b0;
    btn_clear = 1'b0;
    tick(DB + 6);
    $display("Random: stage=%0d in1=%0h in2=%0h mode=%0h", stage, in1, in2, mode);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
